// File: rtl/cdiv.sv
// cdiv: iterative fixed-point complex divider, q = a*conj(b)/|b|^2.
// Optional CDIV_ROUND_EN: one extra quotient bit, round half away from zero.
module cdiv #(
    parameter int AWIDTH = 16,
    parameter int BWIDTH = 18,
    parameter int QWIDTH = 24,
    parameter int QFRAC  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [AWIDTH-1:0] ar,
    input  logic signed [AWIDTH-1:0] ai,
    input  logic signed [BWIDTH-1:0] br,
    input  logic signed [BWIDTH-1:0] bi,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [QWIDTH-1:0] pr,
    output logic signed [QWIDTH-1:0] pi,
    output logic                     div0,
    output logic                     ovf
);
    localparam int PW = AWIDTH + BWIDTH;
    localparam int SW = PW + 1;
    localparam int DW = 2 * BWIDTH;
    localparam int NW = SW + QFRAC;
`ifdef CDIV_ROUND_EN
    localparam int ST = QWIDTH + 1;
`else
    localparam int ST = QWIDTH;
`endif
    localparam int CW = $clog2(ST + 1);
    localparam logic [QWIDTH:0] QMAX = {2'b00, {(QWIDTH-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_SUM, S_DIV, S_FIN, S_DONE
    } state_t;

    state_t state, nxt;

    logic signed [AWIDTH-1:0] ar_q, ai_q;
    logic signed [BWIDTH-1:0] br_q, bi_q;
    logic signed [PW-1:0]     p_rr, p_ii, p_ir, p_ri;
    logic signed [DW-1:0]     s_r, s_i;
    logic [DW-1:0]            d, rem_r, rem_i;
    logic [ST-1:0]            lo_r, lo_i, q_r, q_i;
    logic                     neg_r, neg_i, big_r, big_i, zero;
    logic [CW-1:0]            cnt;

    logic signed [SW-1:0] nr, ni;
    logic [SW-1:0]        mr, mi;
    logic [NW-1:0]        n_r, n_i, hi_r, hi_i;
    logic [DW-1:0]        d_c;
    logic [DW:0]          t_r, t_i;
    logic                 ge_r, ge_i;
    logic [DW-1:0]        nrem_r, nrem_i;
    logic [QWIDTH:0]      f_r, f_i;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Magnitude from quotient bits, saturate, then reapply the sign.
    function automatic logic [QWIDTH:0] fin(input logic [ST-1:0] q,
                                            input logic big,
                                            input logic neg);
        logic [QWIDTH:0] m;
        logic            s;
`ifdef CDIV_ROUND_EN
        m = (QWIDTH+1)'(q[ST-1:1]) + (QWIDTH+1)'(q[0]);
`else
        m = (QWIDTH+1)'(q);
`endif
        s = big || (m > QMAX);
        if (s) m = QMAX;
        if (neg) m = -m;
        return {s, m[QWIDTH-1:0]};
    endfunction

    // Numerators, divisor and per-bit restoring divider step.
    always_comb begin
        nr   = SW'(p_rr) + SW'(p_ii);
        ni   = SW'(p_ir) - SW'(p_ri);
        mr   = nr[SW-1] ? SW'(-nr) : SW'(nr);
        mi   = ni[SW-1] ? SW'(-ni) : SW'(ni);
        n_r  = {mr, {QFRAC{1'b0}}};
        n_i  = {mi, {QFRAC{1'b0}}};
        hi_r = n_r >> QWIDTH;
        hi_i = n_i >> QWIDTH;
        d_c  = $unsigned(s_r) + $unsigned(s_i);
        t_r  = {rem_r, lo_r[ST-1]};
        t_i  = {rem_i, lo_i[ST-1]};
        ge_r = t_r >= {1'b0, d};
        ge_i = t_i >= {1'b0, d};
        nrem_r = ge_r ? DW'(t_r - {1'b0, d}) : DW'(t_r);
        nrem_i = ge_i ? DW'(t_i - {1'b0, d}) : DW'(t_i);
        f_r  = fin(q_r, big_r, neg_r);
        f_i  = fin(q_i, big_i, neg_i);
    end

    // State register; reset wins over ce.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else if (ce) state <= nxt;
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: if (in_valid) nxt = S_MUL;
            S_MUL:  nxt = S_SUM;
            S_SUM:  nxt = S_DIV;
            S_DIV:  if (cnt == '0) nxt = S_FIN;
            S_FIN:  nxt = S_DONE;
            S_DONE: if (out_ready) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, products, divider load/shift, result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pr   <= '0;
            pi   <= '0;
            div0 <= 1'b0;
            ovf  <= 1'b0;
        end else if (ce) begin
            unique case (state)
                S_IDLE: begin
                    ar_q <= ar;
                    ai_q <= ai;
                    br_q <= br;
                    bi_q <= bi;
                end
                S_MUL: begin
                    p_rr <= PW'(ar_q * br_q);
                    p_ii <= PW'(ai_q * bi_q);
                    p_ir <= PW'(ai_q * br_q);
                    p_ri <= PW'(ar_q * bi_q);
                    s_r  <= DW'(br_q * br_q);
                    s_i  <= DW'(bi_q * bi_q);
                end
                S_SUM: begin
                    d     <= d_c;
                    zero  <= (d_c == '0);
                    neg_r <= nr[SW-1];
                    neg_i <= ni[SW-1];
                    big_r <= hi_r >= NW'(d_c);
                    big_i <= hi_i >= NW'(d_c);
                    rem_r <= DW'(hi_r);
                    rem_i <= DW'(hi_i);
`ifdef CDIV_ROUND_EN
                    lo_r  <= {n_r[QWIDTH-1:0], 1'b0};
                    lo_i  <= {n_i[QWIDTH-1:0], 1'b0};
`else
                    lo_r  <= n_r[QWIDTH-1:0];
                    lo_i  <= n_i[QWIDTH-1:0];
`endif
                    q_r   <= '0;
                    q_i   <= '0;
                    cnt   <= CW'(ST - 1);
                end
                S_DIV: begin
                    rem_r <= nrem_r;
                    rem_i <= nrem_i;
                    lo_r  <= lo_r << 1;
                    lo_i  <= lo_i << 1;
                    q_r   <= {q_r[ST-2:0], ge_r};
                    q_i   <= {q_i[ST-2:0], ge_i};
                    cnt   <= cnt - 1'b1;
                end
                S_FIN: begin
                    if (zero) begin
                        pr   <= '0;
                        pi   <= '0;
                        div0 <= 1'b1;
                        ovf  <= 1'b0;
                    end else begin
                        pr   <= f_r[QWIDTH-1:0];
                        pi   <= f_i[QWIDTH-1:0];
                        div0 <= 1'b0;
                        ovf  <= f_r[QWIDTH] | f_i[QWIDTH];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cdiv.sv
// tb_cdiv: directed vectors and handshake corner cases for cdiv.
// Build with CDIV_ROUND_EN defined to check the rounding variant.
module tb_cdiv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, div0, ovf;
    logic signed [15:0] ar = '0, ai = '0;
    logic signed [17:0] br = '0, bi = '0;
    logic signed [23:0] pr, pi;

`ifdef CDIV_ROUND_EN
    localparam int LAT = 28;
`else
    localparam int LAT = 27;
`endif

    cdiv dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .in_valid(in_valid), .in_ready(in_ready),
        .ar(ar), .ai(ai), .br(br), .bi(bi),
        .out_valid(out_valid), .out_ready(out_ready),
        .pr(pr), .pi(pi), .div0(div0), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int    a_r, a_i, b_r, b_i;
        int    e_r, e_i;
        bit    e_d0, e_ov;
    } vec_t;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic start(input int a_r, input int a_i,
                         input int b_r, input int b_i);
        @(negedge clk);
        chk("in_ready_idle", longint'(in_ready), 1);
        ar = 16'(a_r);
        ai = 16'(a_i);
        br = 18'(b_r);
        bi = 18'(b_i);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(input int ce_at, output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == ce_at) ce = 1'b0;
            if (n == ce_at + 3) ce = 1'b1;
        end
        if (!out_valid) chk("timeout", 0, 1);
    endtask

    vec_t tv[12];
    int   n;
    bit   seen;

    initial begin
        tv[0]  = '{"2/1",      2,  0, 1,  0,  131072, 0, 0, 0};
        tv[1]  = '{"i",        1,  1, 1, -1,  0, 65536, 0, 0};
`ifdef CDIV_ROUND_EN
        tv[2]  = '{"2/3",      2,  0, 3,  0,  43691, 0, 0, 0};
        tv[3]  = '{"-2/3",    -2,  0, 3,  0, -43691, 0, 0, 0};
`else
        tv[2]  = '{"2/3",      2,  0, 3,  0,  43690, 0, 0, 0};
        tv[3]  = '{"-2/3",    -2,  0, 3,  0, -43690, 0, 0, 0};
`endif
        tv[4]  = '{"div0",     5, -7, 0,  0,  0, 0, 1, 0};
        tv[5]  = '{"sat_i", 32767,  0, 0,  1,  0, -8388607, 0, 1};
        tv[6]  = '{"-4/1",    -4,  0, 1,  0, -262144, 0, 0, 0};
        tv[7]  = '{"-i",       1,  0, 0,  1,  0, -65536, 0, 0};
        tv[8]  = '{"-1/3",    -1,  0, 3,  0, -21845, 0, 0, 0};
        tv[9]  = '{"127",    127,  0, 1,  0,  8323072, 0, 0, 0};
        tv[10] = '{"128sat", 128,  0, 1,  0,  8388607, 0, 0, 1};
        tv[11] = '{"-128sat",-128, 0, 1,  0, -8388607, 0, 0, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_pr", longint'(pr), 0);
        chk("rst_pi", longint'(pi), 0);
        chk("rst_div0", longint'(div0), 0);
        chk("rst_ovf", longint'(ovf), 0);
        rst_n = 1'b1;

        for (int k = 0; k < 12; k++) begin
            start(tv[k].a_r, tv[k].a_i, tv[k].b_r, tv[k].b_i);
            wait_out(-1, n);
            chk({tv[k].nm, "_lat"}, n, LAT);
            chk({tv[k].nm, "_pr"}, longint'(pr), tv[k].e_r);
            chk({tv[k].nm, "_pi"}, longint'(pi), tv[k].e_i);
            chk({tv[k].nm, "_div0"}, longint'(div0), longint'(tv[k].e_d0));
            chk({tv[k].nm, "_ovf"}, longint'(ovf), longint'(tv[k].e_ov));
            @(posedge clk);
            #1 chk({tv[k].nm, "_drop"}, longint'(out_valid), 0);
        end

        out_ready = 1'b0;
        start(2, 0, 1, 0);
        wait_out(-1, n);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", longint'(out_valid), 1);
            chk("stall_pr", longint'(pr), 131072);
            chk("stall_in_ready", longint'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_valid", longint'(out_valid), 0);
        chk("rel_in_ready", longint'(in_ready), 1);
        chk("rel_pr_hold", longint'(pr), 131072);

        start(2, 0, 3, 0);
        wait_out(10, n);
        chk("ce_lat", n, LAT + 3);
        chk("ce_pr", longint'(pr), tv[2].e_r);
        @(posedge clk);
        #1;

        start(5, 5, 1, 0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_in_ready", longint'(in_ready), 1);
        chk("mid_rst_pr", longint'(pr), 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        chk("no_stale", longint'(seen), 0);

        start(-4, 0, 1, 0);
        wait_out(-1, n);
        chk("post_lat", n, LAT);
        chk("post_pr", longint'(pr), -262144);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
